// File: rtl/video_timing_if.sv
// video_timing_if: raster timing bundle from the timing generator to the pixel stages
interface video_timing_if #(parameter int POS_W = 19);
  logic             hsync;
  logic             vsync;
  logic             blank;
  logic [POS_W-1:0] pixel_pos;
  logic [10:0]      x;
  logic [9:0]       y;
  logic             frame_start;
  logic             line_start;
  modport master(output hsync, vsync, blank, pixel_pos, x, y, frame_start, line_start);
  modport slave(input hsync, vsync, blank, pixel_pos, x, y, frame_start, line_start);
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running H/V counters producing sync, blank, coordinates and a linear pixel index
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int POS_W    = 19
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  video_timing_if.master vt
);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_HS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_HE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] V_VS   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_VE   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic        HS_ACT = HS_POL != 0;
  localparam logic        VS_ACT = VS_POL != 0;
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("video_timing_gen: every porch and sync width must be >= 1");
  end
  logic [11:0]      h_cnt, h_nxt;
  logic [10:0]      v_cnt, v_nxt;
  logic [POS_W-1:0] pos_cnt, pos_nxt;
  logic             h_wrap, v_wrap, active, hs_on, vs_on, last_px;
  logic             hsync_q, vsync_q, blank_q, fs_q, ls_q;
  logic [POS_W-1:0] pos_q;
  logic [10:0]      x_q;
  logic [9:0]       y_q;
  always_comb begin
    h_wrap  = h_cnt == H_LAST;
    v_wrap  = v_cnt == V_LAST;
    active  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_on   = (h_cnt >= H_HS) && (h_cnt < H_HE);
    vs_on   = (v_cnt >= V_VS) && (v_cnt < V_VE);
    last_px = (h_cnt == H_ACT - 12'd1) && (v_cnt == V_ACT - 11'd1);
    h_nxt   = h_wrap ? '0 : h_cnt + 12'd1;
    v_nxt   = !h_wrap ? v_cnt : v_wrap ? '0 : v_cnt + 11'd1;
    pos_nxt = last_px ? '0 : active ? pos_cnt + POS_W'(1) : pos_cnt;
  end
  // outputs decode the pre-advance counters so every output shares one cycle of latency
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      pos_cnt <= '0;
      hsync_q <= ~HS_ACT;
      vsync_q <= ~VS_ACT;
      blank_q <= 1'b1;
      pos_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (i_enable) begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      pos_cnt <= pos_nxt;
      hsync_q <= hs_on ~^ HS_ACT;
      vsync_q <= vs_on ~^ VS_ACT;
      blank_q <= !active;
      pos_q   <= active ? pos_cnt : '0;
      x_q     <= active ? h_cnt[10:0] : '0;
      y_q     <= active ? v_cnt[9:0] : '0;
      fs_q    <= (h_cnt == '0) && (v_cnt == '0);
      ls_q    <= h_cnt == '0;
    end
  end
  assign vt.hsync       = hsync_q;
  assign vt.vsync       = vsync_q;
  assign vt.blank       = blank_q;
  assign vt.pixel_pos   = pos_q;
  assign vt.x           = x_q;
  assign vt.y           = y_q;
  assign vt.frame_start = fs_q;
  assign vt.line_start  = ls_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench on a reduced raster, with an inverted-polarity twin
module tb_video_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [18:0] pos;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fs;
    logic        ls;
  } exp_t;
  localparam exp_t RST = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, pos: '0, x: '0, y: '0, fs: 1'b0, ls: 1'b0};
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_enable = 1'b1;
  int   n_tests = 0, n_fail = 0;
  exp_t q[$];
  video_timing_if #(.POS_W(19)) vt();
  video_timing_if #(.POS_W(19)) vn();
  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .HS_POL(1), .VS_POL(1), .POS_W(19))
    dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .vt(vt));
  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .HS_POL(0), .VS_POL(0), .POS_W(19))
    dut_n (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .vt(vn));
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    logic act;
    act     = h < HA && v < VA;
    e.hs    = h >= HA + HF && h < HA + HF + HS;
    e.vs    = v >= VA + VF && v < VA + VF + VS;
    e.blank = !act;
    e.pos   = act ? 19'(v * HA + h) : '0;
    e.x     = act ? 11'(h) : '0;
    e.y     = act ? 10'(v) : '0;
    e.fs    = h == 0 && v == 0;
    e.ls    = h == 0;
    return e;
  endfunction
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    int   mh, mv;
    exp_t last;
    mh = 0; mv = 0; last = RST;
    forever begin
      @(posedge i_clk);
      if (!i_rst_n) begin
        mh = 0; mv = 0; last = RST;
      end else if (i_enable) begin
        last = model(mh, mv);
        mh = (mh == HT - 1) ? 0 : mh + 1;
        if (mh == 0) mv = (mv == VT - 1) ? 0 : mv + 1;
      end
      q.push_back(last);
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!i_rst_n) e = RST;
        chk("outputs", {vt.hsync, vt.vsync, vt.blank, vt.pixel_pos, vt.x, vt.y, vt.frame_start, vt.line_start}, e);
        chk("inv_syncs", {vn.hsync, vn.vsync}, {~e.hs, ~e.vs});
      end
    end
  end
  initial begin
    int nb, nv, nfs, nls, nhn, fs0, fs1, lim;
    logic [18:0] p;
    repeat (3) step();
    chk("rst_blank", vt.blank, 1'b1);
    chk("rst_hsync", vt.hsync, 1'b0);
    chk("rst_hsync_n", vn.hsync, 1'b1);
    chk("rst_pos", vt.pixel_pos, 19'd0);
    chk("rst_fs", {vt.frame_start, vt.line_start}, 2'b00);
    i_rst_n = 1'b1;
    step();
    chk("first_edge", {vt.frame_start, vt.line_start, vt.blank, vt.pixel_pos, vt.x, vt.y}, {3'b110, 19'd0, 11'd0, 10'd0});
    nb = 0; nv = 0; nfs = 0; nls = 0; nhn = 0; fs0 = -1; fs1 = -1;
    for (int i = 0; i < 2 * FT; i++) begin
      nb  += int'(!vt.blank);
      nv  += int'(vt.vsync);
      nls += int'(vt.line_start);
      nhn += int'(!vn.hsync);
      if (vt.frame_start) begin
        nfs++;
        if (fs0 < 0) fs0 = i; else fs1 = i;
      end
      step();
    end
    chk("active_cycles", nb, 2 * HA * VA);
    chk("vsync_cycles", nv, 2 * VS * HT);
    chk("line_starts", nls, 2 * VT);
    chk("hsync_n_low", nhn, 2 * VT * HS);
    chk("frame_starts", nfs, 2);
    chk("frame_period", fs1 - fs0, FT);
    lim = 0;
    while (lim < FT && !(vt.y == 10'd1 && vt.x == 11'd0 && !vt.blank)) begin step(); lim++; end
    chk("row1_found", lim < FT, 1'b1);
    chk("row1_pos", vt.pixel_pos, 19'(HA));
    lim = 0;
    while (lim < FT && !(vt.y == 10'(VA - 1) && vt.x == 11'(HA - 1) && !vt.blank)) begin step(); lim++; end
    chk("last_found", lim < FT, 1'b1);
    chk("last_pos", vt.pixel_pos, 19'(HA * VA - 1));
    step();
    lim = 0;
    while (lim < FT && vt.blank) begin step(); lim++; end
    chk("wrap_pos_fs", {vt.pixel_pos, vt.frame_start}, {19'd0, 1'b1});
    lim = 0;
    while (lim < FT && !(vt.x == 11'd4 && vt.y == 10'd2 && !vt.blank)) begin step(); lim++; end
    chk("stall_found", lim < FT, 1'b1);
    p = vt.pixel_pos;
    i_enable = 1'b0;
    repeat (5) step();
    chk("stall_hold", {vt.x, vt.pixel_pos}, {11'd4, p});
    i_enable = 1'b1;
    step();
    chk("stall_resume", {vt.x, vt.pixel_pos}, {11'd5, p + 19'd1});
    lim = 0;
    while (lim < FT && !(vt.y == 10'd3 && vt.x == 11'd5 && !vt.blank)) begin step(); lim++; end
    chk("midrst_found", lim < FT, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_now", {vt.blank, vt.hsync, vn.hsync, vt.pixel_pos, vt.x, vt.y, vt.frame_start},
        {3'b101, 19'd0, 11'd0, 10'd0, 1'b0});
    repeat (2) step();
    i_rst_n = 1'b1;
    step();
    chk("midrst_restart", {vt.frame_start, vt.blank, vt.pixel_pos, vt.x, vt.y}, {2'b10, 19'd0, 11'd0, 10'd0});
    repeat (HT) step();
    chk("after_line", {vt.line_start, vt.y, vt.x}, {1'b1, 10'd1, 11'd0});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
